// File: rtl/alu_seq.sv
// Multi-cycle calculator ALU: add/sub in one pass, shift-add multiply and
// restoring fixed-point divide, reported through a start/done handshake.
module alu_seq #(
    parameter int WIDTH = 4,
    parameter int RES_W = 11,
    parameter int SCALE = 100
) (
    input  logic             clk_ALU,
    input  logic             rst_n_ALU,
    input  logic             start,
    input  logic [WIDTH-1:0] reg_1_from_sw,
    input  logic [WIDTH-1:0] reg_2_from_sw,
    input  logic [3:0]       arif_from_top,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] ind_1,
    output logic [2:0]       control,
    output logic [1:0]       state_dbg
);

    localparam int DVD_W  = WIDTH + $clog2(SCALE + 1);
    localparam int PROD_W = 2 * WIDTH;
    localparam int FULL_W = (PROD_W > DVD_W) ? PROD_W : DVD_W;
    localparam int CNT_W  = $clog2(DVD_W + 1);

    // Handshake: start is sampled only in IDLE; busy rises on the accept edge
    // and falls on the edge that raises the one-cycle done pulse.
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIN} state_t;
    typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_MUL, OP_DIV, OP_DZ, OP_ILL} op_t;

    state_t            state;
    op_t               op;
    logic [WIDTH-1:0]  a_r, b_r;
    logic [PROD_W-1:0] acc, mcand;
    logic [WIDTH-1:0]  mplier;
    logic [DVD_W-1:0]  dq;
    logic [WIDTH:0]    rem;
    logic [CNT_W-1:0]  cnt;
    logic              fin_ph;
    logic [FULL_W-1:0] res_full;
    logic [2:0]        res_stat;

    // One restoring-divide step: dividend bits leave dq's MSB, quotient bits enter its LSB.
    logic [WIDTH:0] rem_sh, rem_nx;
    logic           take;
    assign rem_sh = (rem << 1) | (WIDTH + 1)'(dq[DVD_W-1]);
    assign take   = (rem_sh >= {1'b0, b_r});
    assign rem_nx = take ? (rem_sh - {1'b0, b_r}) : rem_sh;

    assign state_dbg = state;

    always_ff @(posedge clk_ALU or negedge rst_n_ALU) begin
        if (!rst_n_ALU) begin
            state    <= S_IDLE;
            op       <= OP_ADD;
            busy     <= 1'b0;
            done     <= 1'b0;
            ind_1    <= '0;
            control  <= '0;
            a_r      <= '0;
            b_r      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            dq       <= '0;
            rem      <= '0;
            cnt      <= '0;
            fin_ph   <= 1'b0;
            res_full <= '0;
            res_stat <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_r    <= reg_1_from_sw;
                        b_r    <= reg_2_from_sw;
                        busy   <= 1'b1;
                        cnt    <= '0;
                        fin_ph <= 1'b0;
                        acc    <= '0;
                        mcand  <= PROD_W'(reg_1_from_sw);
                        mplier <= reg_2_from_sw;
                        dq     <= DVD_W'(reg_1_from_sw) * DVD_W'(SCALE);
                        rem    <= '0;
                        case (arif_from_top)
                            4'b1110: begin op <= OP_ADD; state <= S_FIN; end
                            4'b1101: begin op <= OP_SUB; state <= S_FIN; end
                            4'b1011: begin op <= OP_MUL; state <= S_MUL; end
                            4'b0111: begin
                                if (reg_2_from_sw == '0) begin
                                    op    <= OP_DZ;
                                    state <= S_FIN;
                                end else begin
                                    op    <= OP_DIV;
                                    state <= S_DIV;
                                end
                            end
                            default: begin op <= OP_ILL; state <= S_FIN; end
                        endcase
                    end
                end
                S_MUL: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) state <= S_FIN;
                end
                S_DIV: begin
                    rem <= rem_nx;
                    dq  <= {dq[DVD_W-2:0], take};
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(DVD_W - 1)) state <= S_FIN;
                end
                S_FIN: begin
                    if (!fin_ph) begin
                        // First pass forms the full-width result; second pass truncates and publishes.
                        fin_ph <= 1'b1;
                        case (op)
                            OP_ADD: begin
                                res_full <= FULL_W'(a_r) + FULL_W'(b_r);
                                res_stat <= 3'd0;
                            end
                            OP_SUB: begin
                                res_full <= FULL_W'((a_r >= b_r) ? (a_r - b_r) : (b_r - a_r));
                                res_stat <= (a_r < b_r) ? 3'd1 : 3'd0;
                            end
                            OP_MUL: begin
                                res_full <= FULL_W'(acc);
                                res_stat <= 3'd0;
                            end
                            OP_DIV: begin
                                res_full <= FULL_W'(dq);
                                res_stat <= 3'd4;
                            end
                            OP_DZ: begin
                                res_full <= '0;
                                res_stat <= 3'd2;
                            end
                            default: begin
                                res_full <= '0;
                                res_stat <= 3'd5;
                            end
                        endcase
                    end else begin
                        fin_ph <= 1'b0;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_IDLE;
                        if (op == OP_DZ || op == OP_ILL) begin
                            control <= res_stat;
                        end else if ((res_full >> RES_W) != '0) begin
                            ind_1   <= '1;
                            control <= 3'd3;
                        end else begin
                            ind_1   <= RES_W'(res_full);
                            control <= res_stat;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
